// File: rtl/ddr_rd_port.sv
// Credit-based DDR read port: one-entry command register toward the DDR UI, outstanding-read
// tracking and a return FIFO reserved ahead of issue. `DDR_RD_PORT_STAT_EN adds an issued-read counter.
module ddr_rd_port #(
  parameter int DW    = 512,
  parameter int AW    = 30,
  parameter int DEPTH = 16,
  parameter int PW    = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          up_en_i,
  input  logic [2:0]    up_cmd_i,
  input  logic [AW-1:0] up_addr_i,
  output logic          up_rdy_o,
  input  logic          up_sel_i,
  output logic          up_rd_valid_o,
  output logic [DW-1:0] up_rd_data_o,
  output logic          app_en_o,
  output logic [2:0]    app_cmd_o,
  output logic [AW-1:0] app_addr_o,
  input  logic          app_rdy_i,
  input  logic          app_rd_data_valid_i,
  input  logic [DW-1:0] app_rd_data_i,
  output logic [PW:0]   outstanding_o,
  output logic          overflow_o,
  output logic [31:0]   rd_cmd_cnt_o
);

  localparam logic [2:0]    CMD_RD  = 3'b001;
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic          cmd_vld;
  logic [2:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [PW:0]   outstanding;
  logic [PW:0]   fifo_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic          overflow_q;

  logic          pend;
  logic [PW+1:0] credit_used;
  logic          accept;
  logic          issue;
  logic          rd_issue;
  logic          fifo_full;
  logic          fifo_wr;
  logic          fifo_pop;

  // Credit counts reads in flight, words already buffered and a read still waiting in the command register.
  assign pend        = cmd_vld & (cmd_q == CMD_RD);
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_cnt} + {{(PW+1){1'b0}}, pend};
  assign up_rdy_o    = (!cmd_vld | app_rdy_i) & (credit_used < {1'b0, CNT_MAX});
  assign accept      = up_en_i & up_rdy_o;
  assign issue       = cmd_vld & app_rdy_i;
  assign rd_issue    = issue & (cmd_q == CMD_RD);
  assign fifo_full   = (fifo_cnt == CNT_MAX);
  assign fifo_wr     = app_rd_data_valid_i & !fifo_full;
  assign fifo_pop    = (fifo_cnt != '0) & up_sel_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cmd_vld <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
    end else if (accept) begin
      cmd_vld <= 1'b1;
      cmd_q   <= up_cmd_i;
      addr_q  <= up_addr_i;
    end else if (issue) begin
      cmd_vld <= 1'b0;
    end
  end

  // Returns after a reset still arrive, so the count floors at zero instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      outstanding <= '0;
    end else if (rd_issue && !app_rd_data_valid_i) begin
      outstanding <= outstanding + CNT_ONE;
    end else if (!rd_issue && app_rd_data_valid_i && (outstanding != '0)) begin
      outstanding <= outstanding - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i && fifo_wr) begin
      mem[wr_ptr] <= app_rd_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        rd_data_q <= mem[rd_ptr];
      end
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (app_rd_data_valid_i && fifo_full) begin
        overflow_q <= 1'b1;
      end
      rd_valid_q <= fifo_pop;
    end
  end

`ifdef DDR_RD_PORT_STAT_EN
  logic [31:0] rd_cmd_cnt;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_cmd_cnt <= '0;
    end else if (rd_issue) begin
      rd_cmd_cnt <= rd_cmd_cnt + 32'd1;
    end
  end

  assign rd_cmd_cnt_o = rd_cmd_cnt;
`else
  assign rd_cmd_cnt_o = '0;
`endif

  assign app_en_o      = cmd_vld;
  assign app_cmd_o     = cmd_q;
  assign app_addr_o    = addr_q;
  assign outstanding_o = outstanding;
  assign overflow_o    = overflow_q;
  assign up_rd_valid_o = rd_valid_q;
  assign up_rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_ddr_rd_port.sv
// Bench for ddr_rd_port: directed scenarios plus random traffic, all checked against a
// queue-based reference model; the bench also plays the DDR side.
module tb_ddr_rd_port;
  localparam int DW = 512;
  localparam int AW = 30;
  localparam int DEPTH = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          up_en_i;
  logic [2:0]    up_cmd_i;
  logic [AW-1:0] up_addr_i;
  logic          up_rdy_o;
  logic          up_sel_i;
  logic          up_rd_valid_o;
  logic [DW-1:0] up_rd_data_o;
  logic          app_en_o;
  logic [2:0]    app_cmd_o;
  logic [AW-1:0] app_addr_o;
  logic          app_rdy_i;
  logic          app_rd_data_valid_i;
  logic [DW-1:0] app_rd_data_i;
  logic [PW:0]   outstanding_o;
  logic          overflow_o;
  logic [31:0]   rd_cmd_cnt_o;

  always #5 clk = ~clk;

  ddr_rd_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk_i               (clk),
    .rstn_i              (rstn_i),
    .up_en_i             (up_en_i),
    .up_cmd_i            (up_cmd_i),
    .up_addr_i           (up_addr_i),
    .up_rdy_o            (up_rdy_o),
    .up_sel_i            (up_sel_i),
    .up_rd_valid_o       (up_rd_valid_o),
    .up_rd_data_o        (up_rd_data_o),
    .app_en_o            (app_en_o),
    .app_cmd_o           (app_cmd_o),
    .app_addr_o          (app_addr_o),
    .app_rdy_i           (app_rdy_i),
    .app_rd_data_valid_i (app_rd_data_valid_i),
    .app_rd_data_i       (app_rd_data_i),
    .outstanding_o       (outstanding_o),
    .overflow_o          (overflow_o),
    .rd_cmd_cnt_o        (rd_cmd_cnt_o)
  );

  // stimulus knobs
  bit            en, sel, ardy, ret, rst, use_fix, chk_on;
  logic [2:0]    cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] fix_data;

  int n_chk, n_fail, dut_acc, ddr_pend;

  // reference model
  bit            m_vld;
  logic [2:0]    m_cmd;
  logic [AW-1:0] m_addr;
  int            m_out;
  logic [DW-1:0] m_fifo[$];
  bit            m_ov;
  bit            m_rv;
  logic [DW-1:0] m_rd;
  logic [31:0]   m_cnt;

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_rdy();
    int used;
    used = m_out + m_fifo.size() + ((m_vld && m_cmd == 3'b001) ? 1 : 0);
    return (!m_vld || app_rdy_i) && (used < DEPTH);
  endfunction

  task automatic compare_all();
    chk("up_rdy", up_rdy_o, m_rdy());
    chk("app_en", app_en_o, m_vld);
    if (m_vld) begin
      chk("app_cmd", app_cmd_o, m_cmd);
      chk("app_addr", app_addr_o, m_addr);
    end
    chk("rd_valid", up_rd_valid_o, m_rv);
    chk("rd_data", up_rd_data_o, m_rd);
    chk("outstanding", outstanding_o, m_out);
    chk("overflow", overflow_o, m_ov);
`ifdef DDR_RD_PORT_STAT_EN
    chk("rd_cmd_cnt", rd_cmd_cnt_o, m_cnt);
`else
    chk("rd_cmd_cnt", rd_cmd_cnt_o, 0);
`endif
  endtask

  task automatic model_step();
    bit rd_iss, acc, rv;
    int pre_size;
    rd_iss   = m_vld && app_rdy_i && (m_cmd == 3'b001);
    acc      = up_en_i && m_rdy();
    rv       = app_rd_data_valid_i;
    pre_size = m_fifo.size();
    if (rd_iss) ddr_pend++;
    if (rv) ddr_pend--;
    if (!rstn_i) begin
      m_vld = 0; m_cmd = '0; m_addr = '0; m_out = 0; m_fifo.delete();
      m_ov = 0; m_rv = 0; m_rd = '0; m_cnt = '0;
    end else begin
      if (rd_iss && !rv) m_out++;
      else if (!rd_iss && rv && m_out > 0) m_out--;
      if (pre_size > 0 && up_sel_i) begin
        m_rd = m_fifo.pop_front();
        m_rv = 1;
      end else begin
        m_rv = 0;
      end
      if (rv) begin
        if (pre_size < DEPTH) m_fifo.push_back(app_rd_data_i);
        else m_ov = 1;
      end
      if (acc) begin
        m_vld = 1; m_cmd = up_cmd_i; m_addr = up_addr_i;
      end else if (m_vld && app_rdy_i) begin
        m_vld = 0;
      end
      if (rd_iss) m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    up_en_i   = en;
    up_cmd_i  = cmd;
    up_addr_i = addr;
    up_sel_i  = sel;
    app_rdy_i = ardy;
    rstn_i    = rst;
    app_rd_data_valid_i = ret && (ddr_pend > 0);
    app_rd_data_i = use_fix ? fix_data : rnd_word();
    #1;
    if (chk_on) compare_all();
    if (rstn_i && up_en_i && up_rdy_o) dut_acc++;
    model_step();
    @(posedge clk);
  endtask

  task automatic drain();
    en = 0; sel = 1; ardy = 1; ret = 1;
    for (int i = 0; i < 200 && (ddr_pend > 0 || m_fifo.size() > 0 || m_vld || m_rv); i++) tick();
    ret = 0;
    tick();
  endtask

  initial begin
    logic [DW-1:0] rec [5];
    en = 0; cmd = '0; addr = '0; sel = 0; ardy = 1; ret = 0; rst = 0;
    use_fix = 0; fix_data = '0; chk_on = 0;
    rstn_i = 0; up_en_i = 0; up_cmd_i = '0; up_addr_i = '0; up_sel_i = 0;
    app_rdy_i = 0; app_rd_data_valid_i = 0; app_rd_data_i = '0;
    n_chk = 0; n_fail = 0; dut_acc = 0; ddr_pend = 0;
    m_vld = 0; m_cmd = '0; m_addr = '0; m_out = 0; m_ov = 0; m_rv = 0; m_rd = '0; m_cnt = '0;

    // reset, with app_rdy_i low on the last reset cycle
    tick();
    ardy = 0;
    tick();
    #1;
    chk("rst_up_rdy", up_rdy_o, 1);
    chk("rst_app_en", app_en_o, 0);
    chk("rst_app_cmd", app_cmd_o, 0);
    chk("rst_app_addr", app_addr_o, 0);
    chk("rst_rd_valid", up_rd_valid_o, 0);
    chk("rst_rd_data", up_rd_data_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_cnt", rd_cmd_cnt_o, 0);
    rst = 1; chk_on = 1;

    // single read, return 3 cycles after issue
    ardy = 1; sel = 1; en = 1; cmd = 3'b001; addr = 30'h100;
    tick();
    en = 0;
    #1;
    chk("t1_app_en", app_en_o, 1);
    chk("t1_app_addr", app_addr_o, 30'h100);
    chk("t1_app_cmd", app_cmd_o, 3'b001);
    tick();
    #1;
    chk("t1_app_en_clr", app_en_o, 0);
    chk("t1_out_1", outstanding_o, 1);
    tick();
    tick();
    ret = 1; use_fix = 1; fix_data = {16{32'hA5A5A5A5}};
    tick();
    ret = 0; use_fix = 0;
    #1;
    chk("t1_out_0", outstanding_o, 0);
    chk("t1_lat_early", up_rd_valid_o, 0);
    tick();
    #1;
    chk("t1_valid", up_rd_valid_o, 1);
    chk("t1_data", up_rd_data_o, {16{32'hA5A5A5A5}});
    drain();

    // credit limit: 20 requested, 16 issue, the rest after 4 returns
    dut_acc = 0; cmd = 3'b001;
    for (int i = 0; i < 24; i++) begin
      en = (dut_acc < 20); addr = 30'h1000 + 30'(i);
      tick();
    end
    #1;
    chk("t2_acc16", dut_acc, 16);
    chk("t2_rdy_low", up_rdy_o, 0);
    chk("t2_out16", outstanding_o, 16);
    for (int i = 0; i < 4; i++) begin
      ret = 1; en = (dut_acc < 20);
      tick();
    end
    ret = 0;
    for (int i = 0; i < 30 && dut_acc < 20; i++) begin
      en = 1;
      tick();
    end
    en = 0;
    tick();
    tick();
    #1;
    chk("t2_acc20", dut_acc, 20);
    chk("t2_out_final", outstanding_o, 16);
    drain();

    // returns held while up_sel_i is low, then released in order
    sel = 0; cmd = 3'b001;
    for (int i = 0; i < 5; i++) begin
      en = 1; addr = 30'h200 + 30'(i);
      tick();
    end
    en = 0;
    tick();
    ret = 1; use_fix = 1;
    for (int i = 0; i < 5; i++) begin
      fix_data = rnd_word();
      rec[i] = fix_data;
      tick();
      #1;
      chk("t3_hold", up_rd_valid_o, 0);
    end
    ret = 0; use_fix = 0;
    tick();
    #1;
    chk("t3_fifo_cnt", dut.fifo_cnt, 5);
    chk("t3_hold2", up_rd_valid_o, 0);
    sel = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("t3_burst_valid", up_rd_valid_o, 1);
      chk("t3_burst_data", up_rd_data_o, rec[i]);
    end
    tick();
    #1;
    chk("t3_burst_end", up_rd_valid_o, 0);
    drain();

    // app_rdy_i low with a command pending
    ardy = 0; en = 1; cmd = 3'b001; addr = 30'h2AA;
    tick();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("t4_en_stable", app_en_o, 1);
      chk("t4_addr_stable", app_addr_o, 30'h2AA);
      chk("t4_rdy_low", up_rdy_o, 0);
      chk("t4_out_0", outstanding_o, 0);
    end
    ardy = 1;
    tick();
    #1;
    chk("t4_issued", app_en_o, 0);
    chk("t4_out_1", outstanding_o, 1);
    tick();
    #1;
    chk("t4_no_dup", outstanding_o, 1);
    en = 1; addr = 30'h2AB;
    tick();
    en = 0; ret = 1;
    tick();
    ret = 0;
    #1;
    chk("t4_same_cycle", outstanding_o, 1);
    tick();
    #1;
    chk("t4_same_cycle2", outstanding_o, 1);
    drain();

    // reset mid-burst with 6 outstanding, then a late return
    sel = 1; cmd = 3'b001;
    for (int i = 0; i < 6; i++) begin
      en = 1; addr = 30'h300 + 30'(i);
      tick();
    end
    en = 0;
    tick();
    #1;
    chk("t5_out6", outstanding_o, 6);
    rst = 0;
    tick();
    rst = 1;
    #1;
    chk("t5_rst_out", outstanding_o, 0);
    chk("t5_rst_en", app_en_o, 0);
    chk("t5_rst_valid", up_rd_valid_o, 0);
    sel = 0; ret = 1;
    tick();
    ret = 0;
    #1;
    chk("t5_late_out", outstanding_o, 0);
    tick();
    #1;
    chk("t5_late_buf", dut.fifo_cnt, 1);
    chk("t5_late_ovf", overflow_o, 0);

    // statistics: 7 reads and 2 other commands since the reset above
    for (int i = 0; i < 9; i++) begin
      en = 1; addr = 30'h400 + 30'(i);
      cmd = (i == 2) ? 3'b000 : (i == 6) ? 3'b010 : 3'b001;
      tick();
    end
    en = 0;
    tick();
    #1;
`ifdef DDR_RD_PORT_STAT_EN
    chk("t6_stat", rd_cmd_cnt_o, 7);
`else
    chk("t6_stat", rd_cmd_cnt_o, 0);
`endif
    chk("t6_out7", outstanding_o, 7);
    drain();

    // force an overflow: returns from before a reset plus a fresh full window
    sel = 0; cmd = 3'b001; dut_acc = 0;
    for (int i = 0; i < 40 && dut_acc < 16; i++) begin
      en = 1; addr = 30'h500 + 30'(i);
      tick();
    end
    en = 0;
    tick();
    rst = 0;
    tick();
    rst = 1; dut_acc = 0;
    for (int i = 0; i < 40 && dut_acc < 16; i++) begin
      en = 1; addr = 30'h600 + 30'(i);
      tick();
    end
    en = 0;
    tick();
    #1;
    chk("t7_out16", outstanding_o, 16);
    ret = 1;
    for (int i = 0; i < 40 && ddr_pend > 0; i++) tick();
    ret = 0;
    #1;
    chk("t7_overflow", overflow_o, 1);
    chk("t7_fifo_full", dut.fifo_cnt, 16);
    drain();
    #1;
    chk("t7_sticky", overflow_o, 1);
    rst = 0;
    tick();
    rst = 1;
    #1;
    chk("t7_ovf_clr", overflow_o, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 199) != 0);
      en   = ($urandom_range(0, 1) == 1);
      cmd  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
      addr = AW'($urandom);
      sel  = ($urandom_range(0, 9) < 7);
      ardy = ($urandom_range(0, 9) < 7);
      ret  = ($urandom_range(0, 1) == 1);
      tick();
    end
    rst = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_rd_port.md
# ddr_rd_port

Credit-based DDR read port between the read engines (`read_op`: activation and parameter readers) and the DDR (MIG-style) user interface. It registers read commands toward DDR and tracks outstanding reads. Return data is buffered in a FIFO whose free space is reserved before each read issues, so the non-stallable DDR return path can never overflow. Buffered data is released to the engines only while an engine read is selected, so no word is lost in the cycles the engines mask `ddr_rd_valid_i`.

## Interface
- `DW`, 512, data width.
- `AW`, 30, DDR address width.
- `DEPTH`, 16, return FIFO depth; power of 2, ≥ 2.
- `PW`, 4, log2(`DEPTH`).

Ports:
- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset; synchronous, active-low.
- `up_en_i` in 1: command request from the read engines.
- `up_cmd_i` in 3: command; 3'b001 = read.
- `up_addr_i` in `AW`: command address.
- `up_rdy_o` out 1: command accepted this cycle when high together with `up_en_i`.
- `up_sel_i` in 1: an engine read is active (`rd_ddr_en_i` | `rd_ddr_param_en_i`); gates FIFO pops.
- `up_rd_valid_o` out 1: return word valid (to `ddr_rd_valid_i`).
- `up_rd_data_o` out `DW`: return word (to `ddr_rd_data_i`).
- `app_en_o` out 1: DDR command valid.
- `app_cmd_o` out 3: DDR command.
- `app_addr_o` out `AW`: DDR address.
- `app_rdy_i` in 1: DDR accepts the command when high with `app_en_o`.
- `app_rd_data_valid_i` in 1: DDR return word valid; cannot be stalled.
- `app_rd_data_i` in `DW`: DDR return word.
- `outstanding_o` out `PW`+1: reads issued but not yet returned.
- `overflow_o` out 1: sticky; a return word arrived while the FIFO was full.
- `rd_cmd_cnt_o` out 32: count of issued reads (see Configuration).

## Operation
- **Command stage.** One-entry register holding `cmd_vld`, cmd and addr. It drives `app_en_o` = `cmd_vld`, `app_cmd_o` and `app_addr_o`.
- **Issue.** A command issues when `app_en_o` & `app_rdy_i`; `cmd_vld` then clears unless a new command is accepted in the same cycle.
- **Credit.** `pend` = `cmd_vld` & (`app_cmd_o` == 3'b001).
  - `up_rdy_o` = (!`cmd_vld` | `app_rdy_i`) & (`outstanding` + `fifo_cnt` + `pend` < `DEPTH`).
  - `up_rdy_o` is combinational from registers and `app_rdy_i`.
  - The credit term is evaluated before the current cycle's issue, return and pop.
- **Outstanding counter.** +1 on each issued read (cmd 3'b001). −1 on each `app_rd_data_valid_i`. Both in the same cycle leaves it unchanged. Saturates at 0; never wraps.
- **Non-read commands.** Forwarded the same way but reserve no credit and do not change `outstanding`.
- **FIFO write.** Every `app_rd_data_valid_i` writes `app_rd_data_i` if `fifo_cnt` < `DEPTH`. If the FIFO is full, the word is dropped and `overflow_o` is set; `overflow_o` clears only on reset.
- **FIFO pop.** Pops when `fifo_cnt` > 0 and `up_sel_i`.
  - The popped word goes to the output registers: `up_rd_valid_o` = 1, `up_rd_data_o` = word.
  - Otherwise `up_rd_valid_o` = 0 and `up_rd_data_o` holds its last value.
- **Simultaneous write and pop** leaves `fifo_cnt` unchanged. Pointers wrap modulo `DEPTH`.
- **Reset (including mid-burst).**
  - Clears `cmd_vld`, the FIFO pointers/count, `outstanding` and `overflow_o`.
  - DDR returns arriving after reset are still written if space exists; `outstanding` stays at 0.

## Timing
- Reset values:
  - `up_rdy_o` = 1 (combinational; `app_rdy_i` irrelevant).
  - `app_en_o` = 0, `app_cmd_o` = 0, `app_addr_o` = 0.
  - `up_rd_valid_o` = 0, `up_rd_data_o` = 0.
  - `outstanding_o` = 0, `overflow_o` = 0, `rd_cmd_cnt_o` = 0.
- Accept at edge N → `app_en_o` high from cycle N+1.
- Back-to-back acceptance at one command per cycle while `app_rdy_i` = 1 and credit is available.
- `app_rd_data_valid_i` at cycle M with `up_sel_i` high → `up_rd_valid_o` at M+2.
- Return throughput: 1 word/cycle.
- Words leave in DDR return order.

## Configuration
- `DDR_RD_PORT_STAT_EN`
  - Defined: `rd_cmd_cnt_o` is a 32-bit counter, +1 per issued read (cmd 3'b001), wraps at 2^32, cleared by reset.
  - Undefined: `rd_cmd_cnt_o` is tied to 0 and no counter logic is built.

## Test plan
- Single read, `app_rdy_i` = 1, addr 0x100 → `app_en_o` one cycle with addr 0x100 and cmd 001. Return word 0xA5… 3 cycles later → `up_rd_valid_o` 2 cycles after the return, data 0xA5…, `outstanding_o` 1→0.
- 20 reads issued with no returns, `DEPTH` = 16 → exactly 16 issued and `up_rdy_o` = 0 at `outstanding_o` = 16. After 4 returns with `up_sel_i` = 1, the remaining 4 reads issue.
- `up_sel_i` = 0 during 5 returns → `up_rd_valid_o` stays 0 and `fifo_cnt` = 5. Raising `up_sel_i` → 5 consecutive valid words in order.
- `app_rdy_i` low for 3 cycles with a command pending → `app_en_o` and addr stable, `up_rdy_o` = 0, no duplicate issue. Same-cycle issue and return → `outstanding_o` unchanged.
- `rstn_i` low one cycle mid-burst with 6 outstanding → next cycle `outstanding_o` = 0, `app_en_o` = 0, `up_rd_valid_o` = 0. A late return is buffered and `overflow_o` stays 0.
- With `DDR_RD_PORT_STAT_EN` defined, 7 reads + 2 non-read commands → `rd_cmd_cnt_o` = 7. Undefined → 0.
